// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory loader:
//   state_e            loader FSM state encoding
//   IMEM_DEPTH         default instruction memory depth in 32-bit words
//   WORD_BYTES         bytes per memory word
//   BYTE_IDX_W         width of the byte-within-word index
//   word_to_byte_addr  converts a word index into a word-aligned byte address
// ---------------------------------------------------------------------------
package imem_pkg;

  typedef enum logic [1:0] {
    ST_COUNT = 2'd0,
    ST_DATA  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  localparam int unsigned IMEM_DEPTH = 1024;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTE_IDX_W = $clog2(WORD_BYTES);

  // Word index k maps to byte address k*4; the two low bits are always zero.
  function automatic logic [31:0] word_to_byte_addr(input logic [31:0] word_idx);
    return {word_idx[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
// Bundles the byte-stream handshake, the instruction memory write port and
// the loader status lines.
//   in_valid/in_data/in_ready  byte stream from the boot source
//   we/waddr/wdata             one-cycle word write into instruction memory
//   busy/done/error/cpu_rst    loader status and active-low core reset
// Modports: master = loader side, slave = byte source / memory / core side.
// ---------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              error;
  logic              cpu_rst;

  modport master (
    input  in_valid, in_data,
    output in_ready, we, waddr, wdata, busy, done, error, cpu_rst
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, we, waddr, wdata, busy, done, error, cpu_rst
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Packs a little-endian byte stream into 32-bit words. The first three bytes
// of a word are stored; the fourth byte completes the word combinationally so
// the caller sees word_valid_o in the same cycle the fourth byte is accepted.
//   clk, rst       clock, asynchronous active-high reset
//   byte_valid_i   a byte is being accepted this cycle
//   byte_i         the accepted byte
//   word_valid_o   pulse: the fourth byte of a word is being accepted
//   word_o         assembled word, valid while word_valid_o is high
// ---------------------------------------------------------------------------
module byte_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [BYTE_IDX_W-1:0] idx_q, idx_d;
  logic [23:0]           asm_q, asm_d;

  // Byte index advance, lane insert and word completion.
  always_comb begin
    idx_d        = idx_q;
    asm_d        = asm_q;
    word_valid_o = 1'b0;
    word_o       = {byte_i, asm_q};
    if (byte_valid_i) begin
      idx_d = idx_q + BYTE_IDX_W'(1);  // wraps 3 -> 0
      case (idx_q)
        2'd0:    asm_d[7:0]   = byte_i;
        2'd1:    asm_d[15:8]  = byte_i;
        2'd2:    asm_d[23:16] = byte_i;
        2'd3:    word_valid_o = 1'b1;
        default: word_valid_o = 1'b0;
      endcase
    end else begin
      idx_d = idx_q;
    end
  end

  // Index and partial-word storage; held through input gaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      asm_q <= 24'h000000;
    end else begin
      idx_q <= idx_d;
      asm_q <= asm_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Receives a program image (4-byte little-endian word count N followed by N
// little-endian words), writes each word to instruction memory at sequential
// word-aligned byte addresses and keeps the core in reset until done.
//   clk, rst   clock, asynchronous active-high reset
//   bus        imem_loader_if master: byte stream in, memory write port out,
//              busy/done/error status and active-low cpu_rst
// Parameters: DEPTH = max accepted word count, ADDR_W = byte address width.
// ---------------------------------------------------------------------------
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH  = IMEM_DEPTH,
  parameter int unsigned ADDR_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.master bus
);

  state_e            state_q, state_d;
  logic [31:0]       count_q, count_d;
  logic [31:0]       word_idx_q, word_idx_d;
  logic              in_ready_q, in_ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              cpu_rst_q, cpu_rst_d;

  logic              accept_s;
  logic              word_valid_s;
  logic [31:0]       word_s;

  // in_ready is registered, so acceptance never loops back combinationally.
  assign accept_s = bus.in_valid & in_ready_q;

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .byte_valid_i (accept_s),
    .byte_i       (bus.in_data),
    .word_valid_o (word_valid_s),
    .word_o       (word_s)
  );

  // Next-state, word bookkeeping and next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;

    case (state_q)
      ST_COUNT: begin
        if (word_valid_s) begin
          count_d = word_s;
          if (word_s == 32'd0) begin
            state_d = ST_DONE;
          end else if (word_s > 32'(DEPTH)) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_COUNT;
        end
      end
      ST_DATA: begin
        if (word_valid_s) begin
          we_d       = 1'b1;
          waddr_d    = ADDR_W'(word_to_byte_addr(word_idx_q));
          wdata_d    = word_s;
          word_idx_d = word_idx_q + 32'd1;
          // Last word: leave DATA now; its write strobe lands in the first DONE cycle.
          if ((word_idx_q + 32'd1) == count_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DONE: state_d = ST_DONE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase

    // Status outputs are a registered function of the upcoming state.
    in_ready_d = (state_d == ST_COUNT) || (state_d == ST_DATA);
    busy_d     = in_ready_d;
    done_d     = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERR);
    cpu_rst_d  = done_d;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_COUNT;
      count_q    <= 32'd0;
      word_idx_q <= 32'd0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cpu_rst_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;
  assign bus.cpu_rst  = cpu_rst_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(32)) bus ();

  imem_loader #(.DEPTH(1024), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  // Write monitor: records every strobe mid-cycle.
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      wa_q.push_back(bus.waddr);
      wd_q.push_back(bus.wdata);
    end
  end

  // Offer one byte after 'gap' idle cycles; returns after the accepting edge (+1).
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    logic got;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'hEE;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); rdy = bus.in_ready;
      @(posedge clk); #1;
      got = rdy;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL send_byte: byte %02h not accepted within 20 cycles (in_ready=%b, required 1)", b, bus.in_ready);
    end
  endtask

  task automatic send_image(input logic [7:0] img[], input int max_gap);
    for (int i = 0; i < img.size(); i++) begin
      send_byte(img[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_dut();
    @(posedge clk); #2;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #2;
    wa_q.delete(); wd_q.delete();
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_final_two_word(input string tag);
    checks++;
    if (wa_q.size() !== 2) begin
      errors++; $display("FAIL %s_wcount: got %0d writes, required 2", tag, wa_q.size());
    end else begin
      checks++;
      if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'hFFC4A303) begin
        errors++; $display("FAIL %s_w0: got %08h@%08h, required FFC4A303@00000000", tag, wd_q[0], wa_q[0]);
      end
      checks++;
      if (wa_q[1] !== 32'h4 || wd_q[1] !== 32'h0062E233) begin
        errors++; $display("FAIL %s_w1: got %08h@%08h, required 0062E233@00000004", tag, wd_q[1], wa_q[1]);
      end
    end
    checks++;
    if ({bus.done, bus.cpu_rst, bus.in_ready, bus.busy, bus.error} !== 5'b11000) begin
      errors++;
      $display("FAIL %s_status: got done,cpu_rst,in_ready,busy,error=%b, required 11000", tag,
               {bus.done, bus.cpu_rst, bus.in_ready, bus.busy, bus.error});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #3;
    checks++;
    if ({bus.in_ready, bus.we, bus.busy, bus.done, bus.error, bus.cpu_rst} !== 6'b0 ||
        bus.waddr !== 32'h0 || bus.wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: got rdy,we,busy,done,err,cpu_rst=%b waddr=%08h wdata=%08h, required all 0",
               {bus.in_ready, bus.we, bus.busy, bus.done, bus.error, bus.cpu_rst}, bus.waddr, bus.wdata);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_release_early: in_ready=%b before first clock, required 0", bus.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL reset_release: in_ready=%b busy=%b, required 1 1", bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_two_word();
    logic [7:0] img[] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'hA3, 8'hC4, 8'hFF, 8'h33, 8'hE2, 8'h62, 8'h00};
    send_image(img, 0);
    // The last strobe coincides with the first DONE cycle.
    @(negedge clk);
    checks++;
    if (bus.we !== 1'b1 || bus.done !== 1'b1) begin
      errors++; $display("FAIL two_word_last_strobe: we=%b done=%b, required 1 1", bus.we, bus.done);
    end
    idle(3);
    check_final_two_word("two_word");
  endtask

  task automatic test_zero_and_overflow();
    logic [7:0] zero_img[] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] ovf_img[]  = '{8'h01, 8'h04, 8'h00, 8'h00};
    logic [7:0] max_img[]  = '{8'h00, 8'h04, 8'h00, 8'h00};
    reset_dut();
    send_image(zero_img, 0);
    idle(3);
    checks++;
    if (bus.done !== 1'b1 || bus.cpu_rst !== 1'b1 || wa_q.size() !== 0) begin
      errors++; $display("FAIL zero_count: done=%b cpu_rst=%b writes=%0d, required 1 1 0", bus.done, bus.cpu_rst, wa_q.size());
    end
    reset_dut();
    send_image(ovf_img, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    idle(6);
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.error, bus.cpu_rst, bus.done, bus.busy, bus.in_ready} !== 5'b10000 || wa_q.size() !== 0) begin
      errors++;
      $display("FAIL overflow: err,cpu_rst,done,busy,rdy=%b writes=%0d, required 10000 0",
               {bus.error, bus.cpu_rst, bus.done, bus.busy, bus.in_ready}, wa_q.size());
    end
    reset_dut();
    send_image(max_img, 0);
    @(negedge clk);
    checks++;
    if (bus.error !== 1'b0 || bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL depth_boundary: error=%b busy=%b in_ready=%b, required 0 1 1", bus.error, bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_gapped();
    logic [7:0] img[] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'hA3, 8'hC4, 8'hFF, 8'h33, 8'hE2, 8'h62, 8'h00};
    reset_dut();
    send_image(img, 7);
    idle(3);
    check_final_two_word("gapped");
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] part[] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'hA3, 8'hC4, 8'hFF, 8'h33, 8'hE2};
    logic [7:0] img[]  = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    reset_dut();
    send_image(part, 0);
    checks++;
    if (wa_q.size() !== 1) begin
      errors++; $display("FAIL mid_load_pre: writes=%0d before reset, required 1", wa_q.size());
    end
    rst = 1'b1;
    #2;
    checks++;
    if ({bus.in_ready, bus.we, bus.busy, bus.done, bus.error, bus.cpu_rst} !== 6'b0 ||
        bus.waddr !== 32'h0 || bus.wdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_load_reset: rdy,we,busy,done,err,cpu_rst=%b waddr=%08h wdata=%08h, required all 0",
               {bus.in_ready, bus.we, bus.busy, bus.done, bus.error, bus.cpu_rst}, bus.waddr, bus.wdata);
    end
    @(posedge clk); #2;
    wa_q.delete(); wd_q.delete();
    rst = 1'b0;
    @(posedge clk); #1;
    send_image(img, 0);
    idle(3);
    checks++;
    if (wa_q.size() !== 1 || wa_q[0] !== 32'h0 || wd_q[0] !== 32'h00000013 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL reload: writes=%0d first=%08h@%08h done=%b, required 1 00000013@00000000 1",
               wa_q.size(), (wd_q.size() > 0) ? wd_q[0] : 32'hX, (wa_q.size() > 0) ? wa_q[0] : 32'hX, bus.done);
    end
  endtask

  task automatic test_post_done();
    int n_before;
    n_before = wa_q.size();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.we !== 1'b0) begin
        errors++; $display("FAIL post_done_c%0d: in_ready=%b we=%b, required 0 0", i, bus.in_ready, bus.we);
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.cpu_rst !== 1'b1 || bus.busy !== 1'b0 || wa_q.size() !== n_before) begin
      errors++;
      $display("FAIL post_done_state: done=%b cpu_rst=%b busy=%b writes=%0d, required 1 1 0 %0d",
               bus.done, bus.cpu_rst, bus.busy, wa_q.size(), n_before);
    end
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_zero_and_overflow();
    test_gapped();
    test_reset_mid_load();
    test_post_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
